// File: rtl/instruction_fetch.sv
// instruction_fetch: PC holder and ROM requester; pairs each 1-cycle-latency ROM word with its PC.
// Rev 1.0
`default_nettype none

module instruction_fetch #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_data,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_addr,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  output logic [31:0]           instr_count
);

  typedef enum logic [0:0] {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] pend_pc_q, pend_pc_d;
  logic [31:0]           count_q, count_d;
  logic                  accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= BOOT;
      fetch_pc_q <= RESET_PC;
      pend_pc_q  <= RESET_PC;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pend_pc_q  <= pend_pc_d;
      count_q    <= count_d;
    end
  end

  assign accept = (state_q == RUN) & ~stall & ~redirect;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pend_pc_d  = pend_pc_q;
    count_d    = count_q + {31'd0, accept};
    imem_addr  = fetch_pc_q;

    if (redirect) begin
      imem_addr  = redirect_addr;
      pend_pc_d  = redirect_addr;
      fetch_pc_d = redirect_addr + 1'b1;
      state_d    = RUN;
    end else if (state_q == BOOT) begin
      // Stall is ignored here: there is no valid word yet to hold.
      pend_pc_d  = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + 1'b1;
      state_d    = RUN;
    end else if (stall) begin
      // Re-read the held word so it is presented again next cycle.
      imem_addr = pend_pc_q;
    end else begin
      pend_pc_d  = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + 1'b1;
    end
  end

  assign instr       = imem_data;
  assign instr_pc    = pend_pc_q;
  assign instr_valid = (state_q == RUN);
  assign instr_count = count_q;

endmodule

`default_nettype wire
